// File: rtl/rriot_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rriot_bus_master                                                         |
// | 6502-style RRIOT bus initiator driven by a host command/response         |
// | handshake, with a synchronised peripheral interrupt.                     |
// | Optional macro BM_RETRY_EN: re-run reads that see no OE.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rriot_bus_master #(
  parameter int DIV       = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [10:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        phi2,
  output logic        we_n,
  output logic [9:0]  A,
  output logic [7:0]  DI,
  input  logic [7:0]  DO,
  input  logic        OE,
  output logic        cs1_n,
  output logic        rs_n,
  input  logic        irq_n,
  output logic        irq_level,
  output logic        irq_pulse
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_phi2, w_phi2;
  logic            r_we_n, w_we_n;
  logic [9:0]      r_a, w_a;
  logic [7:0]      r_di, w_di;
  logic            r_cs1_n, w_cs1_n;
  logic            r_rs_n, w_rs_n;
  logic            r_rsp_valid, w_rsp_valid;
  logic [7:0]      r_rsp_rdata, w_rsp_rdata;
  logic            r_rsp_nack, w_rsp_nack;
  logic            r_irq_meta, r_irq_level, r_irq_pulse;

`ifdef BM_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0]   r_retry, w_retry;
  logic            r_rom, w_rom;
`endif

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_phi2      = r_phi2;
    w_we_n      = r_we_n;
    w_a         = r_a;
    w_di        = r_di;
    w_cs1_n     = r_cs1_n;
    w_rs_n      = r_rs_n;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_nack  = r_rsp_nack;
`ifdef BM_RETRY_EN
    w_retry     = r_retry;
    w_rom       = r_rom;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state = S_ADDR;
          w_cnt   = '0;
          w_phi2  = 1'b0;
          w_a     = cmd_addr[9:0];
          w_we_n  = ~cmd_we;
          w_di    = cmd_we ? cmd_wdata : 8'h00;
          w_cs1_n = cmd_addr[10];
          w_rs_n  = ~cmd_addr[10];
`ifdef BM_RETRY_EN
          w_retry = '0;
          w_rom   = cmd_addr[10];
`endif
        end
      end
      S_ADDR: begin
        if (r_cnt == C_LAST) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_phi2  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          // Bus cycle ends here: phi2 drops and the peripheral is deselected.
          w_cnt       = '0;
          w_phi2      = 1'b0;
          w_cs1_n     = 1'b1;
          w_rs_n      = 1'b1;
          w_we_n      = 1'b1;
          w_state     = S_RESP;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_we_n ? (OE ? DO : 8'hFF) : 8'h00;
          w_rsp_nack  = r_we_n & ~OE;
`ifdef BM_RETRY_EN
          if (r_we_n && !OE && (r_retry < RW'(MAX_RETRY))) begin
            w_state     = S_GAP;
            w_retry     = r_retry + 1'b1;
            w_rsp_valid = 1'b0;
            w_rsp_rdata = r_rsp_rdata;
            w_rsp_nack  = r_rsp_nack;
          end
`endif
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
`ifdef BM_RETRY_EN
      S_GAP: begin
        w_state = S_ADDR;
        w_cnt   = '0;
        w_cs1_n = r_rom;
        w_rs_n  = ~r_rom;
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phi2      <= 1'b0;
      r_we_n      <= 1'b1;
      r_a         <= '0;
      r_di        <= '0;
      r_cs1_n     <= 1'b1;
      r_rs_n      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_nack  <= 1'b0;
`ifdef BM_RETRY_EN
      r_retry     <= '0;
      r_rom       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_phi2      <= w_phi2;
      r_we_n      <= w_we_n;
      r_a         <= w_a;
      r_di        <= w_di;
      r_cs1_n     <= w_cs1_n;
      r_rs_n      <= w_rs_n;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_nack  <= w_rsp_nack;
`ifdef BM_RETRY_EN
      r_retry     <= w_retry;
      r_rom       <= w_rom;
`endif
    end
  end

  // Interrupt path is independent of the bus FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_meta  <= 1'b0;
      r_irq_level <= 1'b0;
      r_irq_pulse <= 1'b0;
    end else begin
      r_irq_meta  <= ~irq_n;
      r_irq_level <= r_irq_meta;
      r_irq_pulse <= r_irq_meta & ~r_irq_level;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_nack  = r_rsp_nack;
  assign phi2      = r_phi2;
  assign we_n      = r_we_n;
  assign A         = r_a;
  assign DI        = r_di;
  assign cs1_n     = r_cs1_n;
  assign rs_n      = r_rs_n;
  assign irq_level = r_irq_level;
  assign irq_pulse = r_irq_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rriot_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rriot_bus_master                                                      |
// | Directed bench with a transaction-offset model of rriot_bus_master.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rriot_bus_master;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack;
  logic        phi2, we_n, cs1_n, rs_n;
  logic [9:0]  A;
  logic [7:0]  DI;
  logic [7:0]  DO = '0;
  logic        OE = 1'b0;
  logic        irq_n = 1'b1;
  logic        irq_level, irq_pulse;

  int n_chk = 0;
  int n_fail = 0;

  rriot_bus_master #(.DIV(DIV), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .phi2(phi2), .we_n(we_n), .A(A), .DI(DI),
    .DO(DO), .OE(OE), .cs1_n(cs1_n), .rs_n(rs_n), .irq_n(irq_n),
    .irq_level(irq_level), .irq_pulse(irq_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the cycle offset since acceptance (1..2*DIV on the bus).
  bit          m_ok = 0;
  int          m_k = 0;
  bit          m_resp = 0;
  bit          m_we;
  logic [10:0] m_addr;
  logic [7:0]  m_wd, m_rd;
  bit          m_nack;
  bit          m_s1 = 0, m_s2 = 0, m_pulse = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok = 1; m_k = 0; m_resp = 0;
      m_s1 = 0; m_s2 = 0; m_pulse = 0;
    end else if (m_ok) begin
      m_pulse = m_s1 && !m_s2;
      m_s2 = m_s1;
      m_s1 = !irq_n;
      if (m_resp) begin
        if (rsp_ready) m_resp = 0;
      end else if (m_k == 0) begin
        if (cmd_valid) begin
          m_k = 1; m_we = cmd_we; m_addr = cmd_addr; m_wd = cmd_wdata;
        end
      end else if (m_k == 2 * DIV) begin
        m_k = 0; m_resp = 1;
        m_rd = m_we ? 8'h00 : (OE ? DO : 8'hFF);
        m_nack = !m_we && !OE;
      end else begin
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_ready", cmd_ready, (m_k == 0 && !m_resp));
      chk("irq_level", irq_level, m_s2);
      chk("irq_pulse", irq_pulse, m_pulse);
      if (m_k > 0) begin
        chk("phi2", phi2, (m_k > DIV));
        chk("A", A, m_addr[9:0]);
        chk("we_n", we_n, !m_we);
        chk("DI", DI, m_we ? m_wd : 8'h00);
        chk("cs1_n", cs1_n, m_addr[10]);
        chk("rs_n", rs_n, !m_addr[10]);
        chk("rsp_valid_busy", rsp_valid, 0);
      end else begin
        chk("phi2_idle", phi2, 0);
        chk("cs1_n_idle", cs1_n, 1);
        chk("rs_n_idle", rs_n, 1);
        chk("we_n_idle", we_n, 1);
        chk("rsp_valid", rsp_valid, m_resp);
        if (m_resp) begin
          chk("rsp_rdata", rsp_rdata, m_rd);
          chk("rsp_nack", rsp_nack, m_nack);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic do_cmd(input bit we, input logic [10:0] addr, input logic [7:0] wd,
                        input logic [7:0] pdo, input bit poe,
                        input logic [7:0] erd, input bit enack, input int hold);
    int w;
    int lat;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    DO = pdo; OE = poe; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk); w++;
    end
    chk("accept_wait", w, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk); lat++;
    end
    chk("latency", lat, 2 * DIV + 1);
    chk("lit_rdata", rsp_rdata, erd);
    chk("lit_nack", rsp_nack, enack);
    repeat (hold) @(negedge clk);
    chk("held_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  task automatic irq_edge(input bit level, input int exp_pulses);
    int first;
    int pulses;
    first = 0; pulses = 0;
    #2 irq_n = !level;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (irq_pulse) pulses++;
      if (irq_level == level && first == 0) first = n;
    end
    chk("irq_delay", first, 2);
    chk("irq_pulses", pulses, exp_pulses);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_A", A, 10'h000);
    chk("rst_DI", DI, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_nack", rsp_nack, 0);
    @(negedge clk);

    do_cmd(1'b1, 11'h001, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    do_cmd(1'b0, 11'h400, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 5);
    do_cmd(1'b0, 11'h07F, 8'h00, 8'h77, 1'b0, 8'hFF, 1'b1, 0);
    do_cmd(1'b0, 11'h155, 8'h00, 8'h5A, 1'b1, 8'h5A, 1'b0, 2);
    do_cmd(1'b1, 11'h7FF, 8'h81, 8'h00, 1'b1, 8'h00, 1'b0, 1);

    // Reset in the middle of a DATA phase drops the command.
    cmd_we = 1'b1; cmd_addr = 11'h0AA; cmd_wdata = 8'h3E; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_phi2", phi2, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_phi2", phi2, 0);
    chk("mid_rst_cs1", cs1_n, 1);
    chk("mid_rst_rs", rs_n, 1);
    chk("mid_rst_we", we_n, 1);
    chk("mid_rst_ready", cmd_ready, 1);
    @(negedge clk);
    chk("mid_rst_novalid", rsp_valid, 0);

    do_cmd(1'b0, 11'h400, 8'h00, 8'hC3, 1'b1, 8'hC3, 1'b0, 0);

    irq_edge(1'b1, 1);
    irq_edge(1'b0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
